// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle between the ALU operand mux, the logic unit and writeback.
// The slave modport is the logic unit; the master modport is its environment.
interface logic_unit_pipe_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic             in_acc;
   logic             in_last;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             out_zero;
   logic             out_ones;
   logic [CNT_W-1:0] out_beats;

   modport slave (
      input  in_valid, in_op, in_acc, in_last, in1, in2, out_ready,
      output in_ready, out_valid, out, out_zero, out_ones, out_beats
   );

   modport master (
      output in_valid, in_op, in_acc, in_last, in1, in2, out_ready,
      input  in_ready, out_valid, out, out_zero, out_ones, out_beats
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered eight-op bitwise unit with valid/ready on both sides and an
// accumulate mode that folds a chain of beats into a single result.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no chain open; operand A comes from in1
// ACC   | chain open; operand A comes from the accumulator, in_acc ignored
module logic_unit_pipe #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input logic clk,
   input logic rst_n,
   logic_unit_pipe_if.slave bus
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACC  = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out;
   logic             r_out_zero;
   logic             r_out_ones;
   logic [CNT_W-1:0] r_out_beats;

   logic             w_in_ready;
   logic             w_fire;
   logic             w_produce;
   logic             w_open_chain;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_res;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [CNT_W-1:0] w_beats;

   function automatic logic [WIDTH-1:0] f_op(input logic [2:0]       op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      r = '0;
      case (op)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a ^ b;
         3'b011:  r = ~(a | b);
         3'b100:  r = a & ~b;
         3'b101:  r = a | ~b;
         3'b110:  r = a;
         default: r = ~a;
      endcase
      return r;
   endfunction

   assign w_in_ready = !r_out_valid || bus.out_ready;
   assign w_fire     = bus.in_valid && w_in_ready;

   always_comb begin
      w_a          = bus.in1;
      w_produce    = 1'b0;
      w_open_chain = 1'b0;
      w_beats      = CNT_W'(1);
      w_cnt_inc    = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
      if (r_state == S_ACC) begin
         w_a       = r_acc;
         w_produce = w_fire && bus.in_last;
         w_beats   = w_cnt_inc;
      end else begin
         w_produce    = w_fire && (!bus.in_acc || bus.in_last);
         w_open_chain = w_fire && bus.in_acc && !bus.in_last;
      end
      w_res = f_op(bus.in_op, w_a, bus.in2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out       <= '0;
         r_out_zero  <= 1'b0;
         r_out_ones  <= 1'b0;
         r_out_beats <= '0;
      end else begin
         // a new result takes priority over retiring the old one
         if (w_produce) begin
            r_out_valid <= 1'b1;
            r_out       <= w_res;
            r_out_zero  <= ~|w_res;
            r_out_ones  <= &w_res;
            r_out_beats <= w_beats;
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_fire) begin
            case (r_state)
               S_IDLE: begin
                  if (w_open_chain) begin
                     r_acc   <= w_res;
                     r_cnt   <= CNT_W'(1);
                     r_state <= S_ACC;
                  end
               end
               default: begin
                  if (bus.in_last) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_acc <= w_res;
                     r_cnt <= w_cnt_inc;
                  end
               end
            endcase
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out       = r_out;
   assign bus.out_zero  = r_out_zero;
   assign bus.out_ones  = r_out_ones;
   assign bus.out_beats = r_out_beats;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: a chain-level reference model feeds an
// expected-result queue that an independent output monitor drains.
module tb_logic_unit_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic_unit_pipe_if #(.WIDTH(32), .CNT_W(8)) u ();
   logic_unit_pipe_if #(.WIDTH(32), .CNT_W(2)) u2 ();

   logic_unit_pipe #(.WIDTH(32), .CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(u));
   logic_unit_pipe #(.WIDTH(32), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(u2));

   typedef struct {
      logic [31:0] v;
      logic        z;
      logic        o;
      logic [7:0]  b;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          rdy_mode = 0;

   bit          m_chain = 0;
   logic [31:0] m_first;
   logic [2:0]  m_ops[$];
   logic [31:0] m_bs[$];

   logic [2:0]  cur_op;
   logic        cur_acc, cur_last;
   logic [31:0] cur_a, cur_b;

   bit          stalled = 0;
   exp_t        held;

   function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ~(a | b);
         3'd4: return a & ~b;
         3'd5: return a | ~b;
         3'd6: return a;
         default: return ~a;
      endcase
   endfunction

   function automatic void push_exp(input logic [31:0] v, input int beats);
      exp_t e;
      e.v = v;
      e.z = (v == 32'h0);
      e.o = (v == 32'hFFFF_FFFF);
      e.b = (beats > 255) ? 8'd255 : 8'(beats);
      sb.push_back(e);
   endfunction

   // Chain-level model: remember every beat of an open chain, fold at the end.
   function automatic void model_accept();
      logic [31:0] a;
      if (!m_chain) begin
         if (cur_acc && !cur_last) begin
            m_chain = 1;
            m_first = cur_a;
            m_ops.delete();
            m_bs.delete();
            m_ops.push_back(cur_op);
            m_bs.push_back(cur_b);
         end else begin
            push_exp(ref_op(cur_op, cur_a, cur_b), 1);
         end
      end else begin
         m_ops.push_back(cur_op);
         m_bs.push_back(cur_b);
         if (cur_last) begin
            a = m_first;
            foreach (m_ops[i]) a = ref_op(m_ops[i], a, m_bs[i]);
            push_exp(a, m_ops.size());
            m_chain = 0;
         end
      end
   endfunction

   task automatic set_beat(input logic [2:0] op, input logic acc, input logic last,
                           input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #1;
      cur_op = op; cur_acc = acc; cur_last = last; cur_a = a; cur_b = b;
      u.in_valid = 1'b1;
      u.in_op = op; u.in_acc = acc; u.in_last = last; u.in1 = a; u.in2 = b;
   endtask

   task automatic wait_accept();
      int n = 0;
      forever begin
         @(negedge clk);
         if (u.in_ready) break;
         n++;
         if (n > 200) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
            return;
         end
      end
      model_accept();
   endtask

   task automatic send(input logic [2:0] op, input logic acc, input logic last,
                       input logic [31:0] a, input logic [31:0] b);
      set_beat(op, acc, last, a, b);
      wait_accept();
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      u.in_valid = 1'b0;
      u.in1 = $urandom; u.in2 = $urandom; u.in_op = 3'($urandom); u.in_acc = 1'b1; u.in_last = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 || u.out_valid) begin
         @(negedge clk);
         n++;
         if (n > 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            return;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // out_ready driver
   initial begin
      u.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: u.out_ready = 1'b1;
            1: u.out_ready = 1'($urandom_range(0, 1));
            default: u.out_ready = 1'b0;
         endcase
      end
   end

   // output monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 0;
            continue;
         end
         if (stalled) begin
            checks++;
            if (!u.out_valid || u.out !== held.v || u.out_zero !== held.z ||
                u.out_ones !== held.o || u.out_beats !== held.b) begin
               errors++;
               $display("FAIL hold_stable: got v=%b out=%h beats=%0d, required v=1 out=%h beats=%0d",
                        u.out_valid, u.out, u.out_beats, held.v, held.b);
            end
         end
         if (u.out_valid && u.out_ready) begin
            stalled = 0;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got out=%h beats=%0d, required no output", u.out, u.out_beats);
            end else begin
               e = sb.pop_front();
               if (u.out !== e.v || u.out_zero !== e.z || u.out_ones !== e.o || u.out_beats !== e.b) begin
                  errors++;
                  $display("FAIL result: got out=%h z=%b o=%b beats=%0d, required out=%h z=%b o=%b beats=%0d",
                           u.out, u.out_zero, u.out_ones, u.out_beats, e.v, e.z, e.o, e.b);
               end
            end
         end else if (u.out_valid) begin
            stalled = 1;
            held.v = u.out; held.z = u.out_zero; held.o = u.out_ones; held.b = u.out_beats;
         end else begin
            stalled = 0;
         end
      end
   end

   initial begin
      logic [31:0] acc_v;
      int          lens[3];
      rst_n = 1'b0;
      u.in_valid = 1'b0; u.in_op = '0; u.in_acc = 1'b0; u.in_last = 1'b0; u.in1 = '0; u.in2 = '0;
      u2.in_valid = 1'b0; u2.in_op = '0; u2.in_acc = 1'b0; u2.in_last = 1'b0;
      u2.in1 = '0; u2.in2 = '0; u2.out_ready = 1'b1;
      #2;
      chk("reset_out_valid", 32'(u.out_valid), 32'd0);
      chk("reset_out", u.out, 32'd0);
      chk("reset_out_beats", 32'(u.out_beats), 32'd0);
      chk("reset_flags", {30'd0, u.out_zero, u.out_ones}, 32'd0);
      chk("reset_in_ready", 32'(u.in_ready), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // directed single ops and flags
      send(3'b001, 1'b0, 1'b1, 32'hF0F0_1234, 32'h0FF0_FFFF);
      send(3'b011, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF);
      send(3'b010, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF);
      send(3'b000, 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555);
      send(3'b101, 1'b0, 1'b0, 32'h0, 32'h0);
      send(3'b110, 1'b1, 1'b1, 32'h1234_5678, 32'h0);
      for (int op = 0; op < 8; op++)
         for (int k = 0; k < 4; k++)
            send(3'(op), 1'b0, 1'($urandom), $urandom, $urandom);
      idle();
      wait_drain();

      // OR-reduce chain of four words
      send(3'b001, 1'b1, 1'b0, 32'h1, 32'h2);
      send(3'b001, 1'b0, 1'b0, 32'hFFFF_0000, 32'h4);
      send(3'b001, 1'b1, 1'b0, 32'hFFFF_0000, 32'h8);
      send(3'b001, 1'b1, 1'b1, 32'hFFFF_0000, 32'h10);
      idle();
      wait_drain();

      // backpressure: first result held, input stalls for five cycles
      rdy_mode = 2;
      send(3'b010, 1'b0, 1'b0, $urandom, $urandom);
      set_beat(3'b100, 1'b0, 1'b0, $urandom, $urandom);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(u.in_ready), 32'd0);
         chk("bp_out_valid", 32'(u.out_valid), 32'd1);
      end
      rdy_mode = 0;
      wait_accept();
      for (int k = 0; k < 16; k++) send(3'($urandom), 1'b0, 1'b0, $urandom, $urandom);
      idle();
      wait_drain();

      // random mixed chains under random backpressure
      rdy_mode = 1;
      for (int k = 0; k < 120; k++)
         send(3'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), $urandom, $urandom);
      send(3'($urandom), 1'b0, 1'b1, $urandom, $urandom);
      rdy_mode = 0;
      idle();
      wait_drain();

      // reset in the middle of a chain
      send(3'b110, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);
      send(3'b001, 1'b1, 1'b0, 32'h3, 32'h30);
      send(3'b001, 1'b1, 1'b0, 32'h3, 32'h300);
      idle();
      wait_drain();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(u.out_valid), 32'd0);
      chk("midrst_out", u.out, 32'd0);
      chk("midrst_out_beats", 32'(u.out_beats), 32'd0);
      chk("midrst_in_ready", 32'(u.in_ready), 32'd1);
      m_chain = 0;
      @(negedge clk);
      rst_n = 1'b1;
      send(3'b110, 1'b0, 1'b0, 32'h5, 32'h0);
      idle();
      wait_drain();

      // beat counter saturation on the CNT_W=2 instance
      lens[0] = 2; lens[1] = 3; lens[2] = 6;
      foreach (lens[li]) begin
         acc_v = 32'h1;
         for (int k = 0; k < lens[li]; k++) begin
            @(posedge clk);
            #1;
            u2.in_valid = 1'b1; u2.in_op = 3'b001; u2.in_acc = 1'b1;
            u2.in_last = (k == lens[li] - 1); u2.in1 = 32'h1; u2.in2 = 32'h2 << k;
            acc_v = acc_v | (32'h2 << k);
            @(negedge clk);
            chk("sat_in_ready", 32'(u2.in_ready), 32'd1);
            if (k > 0) chk("sat_no_early_out", 32'(u2.out_valid), 32'd0);
         end
         @(posedge clk);
         #1;
         u2.in_valid = 1'b0;
         @(negedge clk);
         chk("sat_out_valid", 32'(u2.out_valid), 32'd1);
         chk("sat_out", u2.out, acc_v);
         chk("sat_out_beats", 32'(u2.out_beats), (lens[li] > 3) ? 32'd3 : 32'(lens[li]));
      end

      checks++;
      if (sb.size() != 0 || m_chain) begin
         errors++;
         $display("FAIL final_scoreboard: %0d results left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1);
   end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the fixed 32-bit OR block in ALU/calc_int.
- Performs one of eight bitwise operations on two WIDTH-bit operands, with a valid/ready handshake on each side.
- Supports an accumulate mode that chains operations over multiple input beats and emits one result at the end of the chain.
- Sits between the ALU operand mux and the result writeback stage.

Parameters:
- WIDTH, 32, operand and result width in bits (≥1).
- CNT_W, 8, width of the beat counter reported with each result.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_op  in  3  operation select.
- in_acc  in  1  beat starts or continues an accumulate chain.
- in_last  in  1  final beat of an accumulate chain.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- out_valid  out  1  result held in the output register.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result.
- out_zero  out  1  result is all zeros.
- out_ones  out  1  result is all ones.
- out_beats  out  CNT_W  number of input beats folded into this result (saturating).

Behaviour:
- Ops (A, B):
  - 000 A&B
  - 001 A|B
  - 010 A^B
  - 011 ~(A|B)
  - 100 A&~B
  - 101 A|~B
  - 110 A
  - 111 ~A
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is combinational, gives full throughput, and has no bubble.
- Latency: one cycle. A result-producing beat accepted at edge N has out_valid=1 after edge N.
- out_valid hold rule: out_valid, out, out_zero, out_ones and out_beats stay stable while out_valid && !out_ready.
- FSM states are IDLE and ACC.
- In IDLE, with in_acc=0:
  - out ← op(in1,in2), out_beats ← 1.
  - in_last is ignored.
- In IDLE, with in_acc=1 and in_last=1:
  - Single-beat chain, behaves exactly as the in_acc=0 case.
- In IDLE, with in_acc=1 and in_last=0:
  - acc ← op(in1,in2), cnt ← 1, go to ACC.
  - No output is produced.
- In ACC, on each accepted beat:
  - A ← acc (in1 is ignored), and in_acc is ignored.
  - If in_last=0: acc ← op(acc,in2), cnt ← cnt+1 (saturating at all-ones). No output.
  - If in_last=1: out ← op(acc,in2), out_beats ← sat(cnt+1), go to IDLE.
- Non-producing beats still obey the in_ready rule, so a stalled output also stalls chain accumulation.
- Output flags: out_zero and out_ones are registered with out, computed from the value being loaded.
- Back-to-back operation:
  - A result loaded while the previous one is being consumed in the same cycle replaces it, and out_valid stays 1.
  - If an output transfer occurs and no new result is loaded, out_valid ← 0.
- Reset values (async, rst_n=0): out_valid=0, out=0, out_zero=0, out_ones=0, out_beats=0, state=IDLE, acc=0, cnt=0.
  - in_ready=1 during reset deassertion.
  - Reset in the middle of a chain discards the partial accumulator. The first beat after reset is treated as an IDLE beat.
- Width rules:
  - All ops are exactly WIDTH bits, with no carry or sign.
  - WIDTH=1 is legal. In that case out_zero = ~out and out_ones = out.
- Inputs are don't-care when in_valid=0 and must not change state.

Test Plan:
- Single ops, WIDTH=32, out_ready=1:
  - in1=32'hF0F0_1234, in2=32'h0FF0_FFFF, op=001 → next cycle out=32'hFFF0_FFFF, out_beats=1.
  - op=011 → out=32'h000F_0000.
  - op=010 → out=32'hFF00_EDCB.
  - Sweep all 8 ops with random operands against a reference model.
- Flags:
  - op=000, in1=32'hAAAA_AAAA, in2=32'h5555_5555 → out=0, out_zero=1, out_ones=0.
  - op=101, in1=0, in2=0 → out=32'hFFFF_FFFF, out_ones=1.
- Accumulate chain (OR-reduce of 4 words):
  - Beat 1: op=001, in_acc=1, in1=32'h1, in2=32'h2.
  - Beats 2–4: op=001, in2=32'h4, 32'h8, 32'h10; beat 4 has in_last=1.
  - Expected: exactly one output, out=32'h1F, out_beats=4. No out_valid pulse for beats 1–3.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 after the first result; out remains stable.
  - Release out_ready → one result transfers per cycle, with no loss or duplication over a 16-beat stream.
- Reset mid-chain:
  - Start a chain with 2 beats, pulse rst_n low asynchronously (mid-cycle) → out_valid=0, out=0, out_beats=0 immediately.
  - Next beat after reset: op=110, in_acc=0, in1=32'h5 → out=32'h5, out_beats=1.
- Counter saturation, CNT_W=2:
  - 6-beat chain → out_beats=3.
